// File: rtl/synch_down_counter_pkg.sv
// Shared constants for the loadable down counter.
// Default width, wrap/one-shot mode encodings, all-ones/zero helpers.
// Values are sized to the widest legal counter and truncated by users.
package synch_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MIN_WIDTH     = 2;
    localparam int MAX_WIDTH     = 16;

    // Encodings for the STOP_AT_ZERO parameter.
    localparam int MODE_WRAP    = 0;
    localparam int MODE_ONESHOT = 1;

    // All-ones pattern for a w-bit counter (the wrap target from zero).
    function automatic logic [MAX_WIDTH-1:0] ones_of(input int w);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Zero pattern, kept alongside ones_of so both terminal values live here.
    function automatic logic [MAX_WIDTH-1:0] zero_of(input int w);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        if (w > MAX_WIDTH) begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/synch_down_counter_dff_ar.sv
// 1-bit D flip-flop, asynchronous active-high reset to 0.
// Latency: q follows d one rising edge later; rst clears q immediately.
// No flow control: d is captured on every edge.
module dff_ar (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Capture d each rising edge; reset forces 0 without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/synch_down_counter.sv
// Loadable synchronous down counter with registered done/borrow pulses.
// Latency: count/done/borrow update 1 edge after load/en; zero is combinational on count.
// No backpressure: load and en are sampled on every rising edge (rst > load > en > hold).
module synch_down_counter
    import synch_down_counter_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int STOP_AT_ZERO = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             done,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] COUNT_ZERO = WIDTH'(zero_of(WIDTH));
    localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);
    localparam bit               ONESHOT    = (STOP_AT_ZERO == MODE_ONESHOT);

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] count_next;
    logic             is_zero;
    logic             is_one;
    logic             step;
    logic             done_next;
    logic             borrow_next;

    assign is_zero = (count == COUNT_ZERO);
    assign is_one  = (count == COUNT_ONE);
    assign zero    = is_zero;

    // Toggle terms of the down-count: bit0 always, bit i only when every lower bit is 0.
    always_comb begin
        logic lower_all_zero;
        lower_all_zero = 1'b1;
        toggle         = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i]      = lower_all_zero;
            lower_all_zero = lower_all_zero & ~count[i];
        end
    end

    // Applying the toggles is count-1 modulo 2^WIDTH; from zero it lands on all ones.
    assign count_dec = count ^ toggle;

    // Next-state selection: load beats en; one-shot mode parks at zero until reloaded.
    always_comb begin
        step        = en & ~(ONESHOT & is_zero);
        count_next  = count;
        done_next   = 1'b0;
        borrow_next = 1'b0;
        if (load) begin
            count_next = load_val;
        end else if (step) begin
            count_next  = count_dec;
            done_next   = is_one;
            borrow_next = is_zero;
        end
    end

    // One reset flop per count bit.
    for (genvar g = 0; g < WIDTH; g++) begin : g_count_bit
        dff_ar u_bit (
            .clk (clk),
            .rst (rst),
            .d   (count_next[g]),
            .q   (count[g])
        );
    end

    // Terminal-event pulses are registered beside count so they line up with the new value.
    dff_ar u_done (
        .clk (clk),
        .rst (rst),
        .d   (done_next),
        .q   (done)
    );

    dff_ar u_borrow (
        .clk (clk),
        .rst (rst),
        .d   (borrow_next),
        .q   (borrow)
    );

endmodule

// File: doc/synch_down_counter.md
Name: synch_down_counter

Overview:
Synchronous binary down counter. It is the count-down counterpart of the team's 4-bit synchronous up counter.
- Parallel load, count enable, registered terminal-event flags.
- Selectable wrap-around or one-shot stop-at-zero mode.
- Used as a loadable interval/timeout timer feeding the up-counter-based datapath and display logic.

Parameters:
WIDTH, 4, counter width in bits (legal range 2..16)
STOP_AT_ZERO, 0, 0 = wrap 0 -> 2^WIDTH-1; 1 = hold at 0 (one-shot)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  count enable; decrement by 1 on edge when high
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value captured when load=1
count  output  WIDTH  current counter value
zero  output  1  combinational, high when count == 0
done  output  1  registered 1-cycle pulse, decrement took count 1 -> 0
borrow  output  1  registered 1-cycle pulse, wrap 0 -> 2^WIDTH-1 (wrap mode only)

Behaviour:
- Reset (rst=1, asynchronous, immediate, overrides everything):
  - count=0, done=0, borrow=0, zero=1.
  - Held while rst=1; release takes effect at the next clock edge.
- Priority per rising edge: rst > load > en > hold.
- load=1:
  - count <= load_val regardless of en.
  - done <= 0, borrow <= 0.
  - load_val=0 is legal and yields count=0 with no done pulse.
- load=0, en=1, count > 1: count <= count-1, done <= 0, borrow <= 0.
- load=0, en=1, count == 1: count <= 0, done <= 1 for exactly one cycle.
- load=0, en=1, count == 0:
  - STOP_AT_ZERO=0: count <= 2^WIDTH-1 (all ones), borrow <= 1 for one cycle, done <= 0.
  - STOP_AT_ZERO=1: count holds 0, borrow <= 0, done <= 0; en ignored until next load.
- load=0, en=0: count holds; done and borrow return to 0 (pulses never stretch).
- Arithmetic is modulo 2^WIDTH. Next count is the XNOR-chain down-count:
  - bit0 toggles every enabled cycle.
  - bit i toggles when all lower bits are 0.
  - Equivalent to count-1 with the borrow discarded.
- Latency:
  - count changes 1 cycle after the enabling edge.
  - done/borrow assert in the same cycle the new count appears (registered alongside count).
  - zero tracks count combinationally with no added latency.
- Rst mid-count or mid-pulse: all outputs go to reset values immediately; a pending done/borrow is lost.
- Simultaneous load and en at count==1: load wins, no done pulse.
- Outputs have no X after reset for any input sequence.

Decomposition:
- Shared package holds:
  - default WIDTH constant (4).
  - mode constants MODE_WRAP=0 and MODE_ONESHOT=1 for STOP_AT_ZERO.
  - the all-ones/zero constants derived from WIDTH.
- Natural sub-module: dff_ar, a 1-bit D flip-flop with asynchronous active-high reset to 0.
  - Instantiated once per count bit via generate.
  - Also instantiated for the done and borrow registers.
- Next-state logic (per-bit toggle terms, load mux, mode gating) stays in the top module.

Test Plan:
1. Assert rst for 2 cycles, release, en=0 -> count=0, zero=1, done=0, borrow=0 held for 5 cycles.
2. From reset, STOP_AT_ZERO=0, en=1 for 17 edges -> count sequence 15,14,...,1,0,15:
   - borrow pulses on first edge (0->15) and again on 17th.
   - done pulses once on the 0 transition (16th edge).
3. load=1 load_val=5 one cycle, then en=1 -> count 5,4,3,2,1,0:
   - done high exactly one cycle coincident with count=0, zero=1 same cycle.
4. STOP_AT_ZERO=1: load 2, en=1 held 6 edges -> 2,1,0,0,0,0:
   - single done pulse, borrow never asserts.
   - a subsequent load 3 restarts the count.
5. count=1, load=1 load_val=9 with en=1 same edge -> count=9, no done. Next edge with en=0 -> count stays 9.
6. count=7 with en=1, assert rst asynchronously mid-cycle (between edges) -> count=0, zero=1 immediately.
   - done/borrow=0.
   - counting resumes from 0 (wraps to 15 in mode 0) after release.
